// File: rtl/dem_dac_pkg.sv
// dem_dac_pkg: shared types and sizing helpers for the DEM-DAC receive path.
package dem_dac_pkg;
  typedef enum logic [1:0] {IDLE, COMB, OUT} cic_state_e;
  function automatic int cic_acc_width(input int in_w, input int order, input int r);
    return in_w + order * $clog2(r);
  endfunction
endpackage

// File: rtl/cic_decimator_integrator.sv
// cic_integrator: one wrapping accumulator; sum_o is the post-update value so a
// chain of stages sees the new values of its predecessors within the same beat.
module cic_integrator #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] sum_o
);
  logic [W-1:0] acc_q;
  assign sum_o = acc_q + x_i;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else if (clear) acc_q <= '0;
    else if (en_i) acc_q <= sum_o;
  end
endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: M=1 decimating CIC, integrators at input rate, combs run by a small FSM.
// Optional CIC_DECIMATOR_ROUND_EN: round-half-up with positive saturation on the output slice.
module cic_decimator
  import dem_dac_pkg::*;
#(
  parameter int IN_WIDTH  = 4,
  parameter int ORDER     = 3,
  parameter int R         = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  input  logic                 out_ready
);
  localparam int ACC_WIDTH = cic_acc_width(IN_WIDTH, ORDER, R);
  localparam int PW = $clog2(R);
  localparam int SW = ORDER > 1 ? $clog2(ORDER) : 1;
  localparam int SH = ACC_WIDTH - OUT_WIDTH;

  cic_state_e state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [ACC_WIDTH-1:0] work_q, work_d, y, ys;
  logic [ORDER-1:0][ACC_WIDTH-1:0] dly_q;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [ACC_WIDTH-1:0] isum [ORDER+1];
  logic init_q, last, take, accept, beat;

  assign isum[0] = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  for (genvar g = 0; g < ORDER; g++) begin : g_int
    cic_integrator #(.W(ACC_WIDTH)) u_int (
      .clk(clk), .reset(reset), .clear(clear), .en_i(accept),
      .x_i(isum[g]), .sum_o(isum[g+1])
    );
  end

  // A result leaving this cycle frees the working register for the next decimation beat.
  assign last = phase_q == PW'(R-1);
  assign take = state_q == OUT && out_ready;
  assign in_ready = init_q && !(last && state_q != IDLE && !take);
  assign accept = in_valid && in_ready;
  assign beat = accept && last;
  assign y = work_q - dly_q[stage_q];
  assign out_valid = state_q == OUT;
  assign out_data = out_q;

`ifdef CIC_DECIMATOR_ROUND_EN
  if (SH > 0) begin : g_rnd
    logic [ACC_WIDTH-1:0] r;
    assign r = y + (ACC_WIDTH'(1) << (SH-1));
    assign ys = (!y[ACC_WIDTH-1] && r[ACC_WIDTH-1]) ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : r;
  end else begin : g_trunc
    assign ys = y;
  end
`else
  assign ys = y;
`endif

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    work_d = work_q;
    out_d = out_q;
    phase_d = accept ? phase_q + 1'b1 : phase_q;
    if (state_q == COMB) begin
      work_d = y;
      stage_d = stage_q + 1'b1;
      if (stage_q == SW'(ORDER-1)) begin
        state_d = OUT;
        out_d = OUT_WIDTH'(ys >> SH);
      end
    end else if (take) begin
      state_d = IDLE;
    end
    if (beat) begin
      state_d = COMB;
      stage_d = '0;
      work_d = isum[ORDER];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      stage_q <= '0;
      work_q <= '0;
      out_q <= '0;
      dly_q <= '0;
      init_q <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      phase_q <= '0;
      stage_q <= '0;
      work_q <= '0;
      out_q <= '0;
      dly_q <= '0;
      init_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      stage_q <= stage_d;
      work_q <= work_d;
      out_q <= out_d;
      init_q <= 1'b1;
      if (state_q == COMB) dly_q[stage_q] <= work_q;
    end
  end
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: random and directed stimulus against an exact-arithmetic CIC model,
// with a scoreboard queue drained by an output monitor.
module tb_cic_decimator;
  localparam int IN_WIDTH = 4, ORDER = 3, R = 64, OUT_WIDTH = 16;
  localparam int ACC = IN_WIDTH + ORDER * $clog2(R);
  localparam int SH = ACC - OUT_WIDTH;

  logic clk = 0, reset = 1, clear = 0, in_valid = 0, out_ready = 0;
  logic [IN_WIDTH-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [OUT_WIDTH-1:0] out_data;

  cic_decimator #(.IN_WIDTH(IN_WIDTH), .ORDER(ORDER), .R(R), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  longint s [ORDER+1];
  longint hist [ORDER+1];
  longint exp_q [$];
  longint last_out = 0;
  int phase = 0, since_rst = 0, n_beat = 0, n_acc = 0, n_out = 0, n_stall = 0, beat_cyc = 0;
  logic ov_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Exact integer CIC: ORDER-th backward difference of the ORDER-fold running sum, then wrap.
  function automatic longint model_out();
    longint y = 0, c = 1, m = longint'(1) << ACC, o;
    for (int k = 0; k <= ORDER; k++) begin
      y += (k % 2 == 1) ? -c * hist[k] : c * hist[k];
      c = c * (ORDER - k) / (k + 1);
    end
    y = ((y % m) + m) % m;
    if (y >= m / 2) y -= m;
`ifdef CIC_DECIMATOR_ROUND_EN
    o = (y + (longint'(1) << (SH - 1))) >>> SH;
    if (o > (longint'(1) << (OUT_WIDTH - 1)) - 1) o = (longint'(1) << (OUT_WIDTH - 1)) - 1;
`else
    o = y >>> SH;
`endif
    return o;
  endfunction

  always @(negedge clk) begin
    if (reset || clear) begin
      for (int k = 0; k <= ORDER; k++) begin s[k] = 0; hist[k] = 0; end
      exp_q.delete();
      phase = 0; since_rst = 0; n_acc = 0; ov_prev = 0;
    end else begin
      since_rst++;
      if (!in_ready && since_rst > 1) begin n_stall++; chk("stall_phase", phase, R - 1); end
      if (out_valid && !ov_prev) chk("latency", cyc - beat_cyc, ORDER + 1);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          chk("out_data", $signed(out_data), exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            last_out = $signed(out_data);
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        s[0] = $signed(in_data);
        for (int k = 1; k <= ORDER; k++) s[k] += s[k-1];
        n_acc++;
        if (phase == R - 1) begin
          for (int k = ORDER; k > 0; k--) hist[k] = hist[k-1];
          hist[0] = s[ORDER];
          exp_q.push_back(model_out());
          n_beat++;
          beat_cyc = cyc;
        end
        phase = (phase + 1) % R;
      end
      ov_prev = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("ready_init_low", in_ready, 0);
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    step();
  endtask

  task automatic run_dc(input int val, input int n, input longint settle);
    int target = n_out + n;
    int g = 0;
    in_valid = 1; out_ready = 1; in_data = IN_WIDTH'(val);
    while (n_out < target && g < n * R + 200) begin step(); g++; end
    chk("dc_count", n_out, target);
    chk("dc_settle", last_out, settle);
  endtask

  task automatic run_random(input int cycles, input int vp, input int rp);
    for (int i = 0; i < cycles; i++) begin
      in_valid = $urandom_range(99) < vp;
      out_ready = $urandom_range(99) < rp;
      in_data = IN_WIDTH'($urandom);
      step();
    end
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    repeat (20) step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic mid_comb_abort(input bit use_clear);
    int nb = n_beat;
    int g = 0;
    in_valid = 1; out_ready = 1;
    while (n_beat == nb && g < 300) begin in_data = IN_WIDTH'($urandom); step(); g++; end
    chk("beat_seen", n_beat, nb + 1);
    in_valid = 0;
    if (use_clear) begin clear = 1; step(); clear = 0; end
    else begin reset = 1; repeat (2) step(); reset = 0; end
    for (int i = 0; i < 8; i++) begin
      step();
      chk(use_clear ? "clr_no_out" : "rst_no_out", out_valid, 0);
    end
    run_random(400, 90, 100);
    drain();
  endtask

  initial begin
    int g, n0, st0;
    do_reset();
    run_dc(1, 6, 4096);
    do_reset();
    run_dc(-8, 600, -32768);
    do_reset();
    run_dc(7, 400, 28672);

    do_reset();
    in_valid = 1; out_ready = 1;
    n0 = n_out; g = 0;
    while (n_out == n0 && g < 300) begin in_data = IN_WIDTH'(n_acc == 0 ? 1 : 0); step(); g++; end
`ifdef CIC_DECIMATOR_ROUND_EN
    chk("impulse", last_out, 33);
`else
    chk("impulse", last_out, 32);
`endif

    do_reset();
    in_valid = 1; out_ready = 1;
    n0 = n_out; g = 0;
    while (n_out == n0 && g < 300) begin in_data = IN_WIDTH'($urandom); step(); g++; end
    out_ready = 0;
    st0 = n_stall;
    for (int i = 0; i < 200; i++) begin in_data = IN_WIDTH'($urandom); step(); end
    chk("stall_seen", n_stall > st0, 1);
    out_ready = 1;
    for (int i = 0; i < 200; i++) begin in_data = IN_WIDTH'($urandom); step(); end
    drain();

    mid_comb_abort(0);
    mid_comb_abort(1);

    run_random(3000, 75, 50);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
